// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared button-event types and tick-ratio helpers
// Purpose: state encoding for the button event FSM and constant helpers that
//          turn clock/event rates into tick counts and counter widths.
// Ports:   none (package).
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    function automatic int ticks_of(input int clk_hz, input int rate_hz);
        return clk_hz / rate_hz;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter must be able to hold the larger of the two tick periods.
    function automatic int cnt_width(input int long_ticks, input int repeat_ticks);
        return $clog2(max_int(long_ticks, repeat_ticks) + 1);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - previous-level register with rise/fall detection
// Purpose: remembers the last sampled button level and flags rising and
//          falling transitions of the current level against it.
// Ports:   i_clk, i_rst_n (async active-low), i_btn level in,
//          o_rise / o_fall combinational edge flags.
module btn_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_rise,
    output logic o_fall
);

    logic r_last_btn;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_btn <= 1'b0;
        end else begin
            r_last_btn <= i_btn;
        end
    end

    // Last level resets to 0, so a button already down at reset release
    // shows up as a rise on the first edge.
    assign o_rise = i_btn & ~r_last_btn;
    assign o_fall = ~i_btn & r_last_btn;

endmodule

// File: rtl/btn_events.sv
// rtl/btn_events.sv - debounced button level to UI event pulses
// Purpose: turns a debounced button level into press/release/short/long/
//          repeat pulses, a held level and a wrapping short-click count.
// Ports:   i_clk, i_rst_n (async active-low), i_debbtn (1 = pressed);
//          o_press, o_release, o_short, o_long, o_repeat one-cycle pulses;
//          o_held level while in long hold; o_clicks 8-bit short count.
module btn_events
    import btn_pkg::*;
#(
    parameter int CLOCK_RATE_HZ = 16_000_000,
    parameter int LONG_PRESS_HZ = 2,
    parameter int REPEAT_HZ     = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_debbtn,
    output logic       o_press,
    output logic       o_release,
    output logic       o_short,
    output logic       o_long,
    output logic       o_repeat,
    output logic       o_held,
    output logic [7:0] o_clicks
);

    localparam int LONG_TICKS   = ticks_of(CLOCK_RATE_HZ, LONG_PRESS_HZ);
    localparam int REPEAT_TICKS = ticks_of(CLOCK_RATE_HZ, REPEAT_HZ);
    localparam int CNT_MAX      = max_int(LONG_TICKS, REPEAT_TICKS) - 1;
    localparam int CNT_W        = cnt_width(LONG_TICKS, REPEAT_TICKS);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    logic w_rise;
    logic w_fall;

    btn_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_press;
    logic             r_release;
    logic             r_short;
    logic             r_long;
    logic             r_repeat;
    logic [7:0]       r_clicks;

    btn_edge u_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_debbtn),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // r_count holds the number of edges elapsed since the press edge (E0),
    // so the PRESSED compare against LONG_TICKS-1 fires at E0+LONG_TICKS.
    // In HELD it restarts at 0 and fires every REPEAT_TICKS edges.
    // A fall is tested before any threshold, so release wins ties.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_clicks  <= 8'd0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_PRESSED;
                        r_count <= '0;
                        r_press <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (w_fall) begin
                        r_state   <= ST_IDLE;
                        r_count   <= '0;
                        r_release <= 1'b1;
                        r_short   <= 1'b1;
                        r_clicks  <= r_clicks + 8'd1;
                    end else if (r_count == LONG_LAST) begin
                        r_state <= ST_HELD;
                        r_count <= '0;
                        r_long  <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        r_state   <= ST_IDLE;
                        r_count   <= '0;
                        r_release <= 1'b1;
                    end else if (r_count == REPEAT_LAST) begin
                        r_count  <= '0;
                        r_repeat <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_short   = r_short;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;
    assign o_held    = (r_state == ST_HELD);
    assign o_clicks  = r_clicks;

`ifdef FORMAL
    always_comb begin
        if (i_rst_n) begin
            assert (int'(r_count) <= CNT_MAX);
            assert (!o_short || o_release);
            assert (!(o_long && o_release));
            assert (o_held == (r_state == ST_HELD));
        end
    end
`endif

endmodule
